// File: rtl/alu_fault_pipe_if.sv
// Operand/result handshake and fault-config bundle for alu_fault_pipe.
// master drives operands and config, slave is the ALU pipe.
interface alu_fault_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int BW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             cfg_we;
  logic [1:0]       cfg_mode;
  logic [BW-1:0]    cfg_bit;
  logic [7:0]       cfg_opmask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;
  logic             carry_flag;
  logic             fault_hit;
  logic [CNT_W-1:0] fault_count;

  modport master (
    output in_valid, A, B, opcode,
    output cfg_we, cfg_mode, cfg_bit, cfg_opmask,
    output out_ready,
    input  in_ready, out_valid, result,
    input  zero_flag, carry_flag, fault_hit,
    input  fault_count
  );

  modport slave (
    input  in_valid, A, B, opcode,
    input  cfg_we, cfg_mode, cfg_bit, cfg_opmask,
    input  out_ready,
    output in_ready, out_valid, result,
    output zero_flag, carry_flag, fault_hit,
    output fault_count
  );
endinterface

// File: rtl/alu_fault_pipe.sv
// Two-stage ALU pipe with programmable result-bit fault injection.
// ALU_FAULT_CNT_EN builds the saturating fault-hit counter.
module alu_fault_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  alu_fault_pipe_if.slave     bus
);
  localparam int BW = $clog2(WIDTH);

  typedef struct packed {
    logic [1:0]    mode;
    logic [BW-1:0] bit_idx;
    logic [7:0]    mask;
  } cfg_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    cfg_t             cfg;
  } s1_t;

  cfg_t cfg;
  s1_t  s1;
  logic s1_valid;
  logic s2_valid;
  logic s1_ready;
  logic s2_ready;

  logic [WIDTH-1:0] s2_res;
  logic             s2_zero;
  logic             s2_carry;
  logic             s2_hit;

  logic [WIDTH:0]   gold;
  logic [WIDTH-1:0] fmask;
  logic [WIDTH-1:0] fres;
  logic             f_en;

  assign s2_ready = !s2_valid || bus.out_ready;
  assign s1_ready = !s1_valid || s2_ready;

  always_comb begin
    gold = '0;
    case (s1.op)
      3'b000: gold = {1'b0, s1.a} + {1'b0, s1.b};
      3'b001: gold = {s1.a < s1.b, s1.a - s1.b};
      3'b010: gold = {1'b0, s1.a & s1.b};
      3'b011: gold = {1'b0, s1.a | s1.b};
      3'b100: gold = {1'b0, s1.a ^ s1.b};
      3'b101: gold = {{WIDTH{1'b0}}, s1.a == s1.b};
      3'b110: gold = {{WIDTH{1'b0}}, s1.a < s1.b};
      default: gold = '0;
    endcase
  end

  // An out-of-range bit index matches no position, leaving fmask empty.
  always_comb begin
    fmask = '0;
    for (int i = 0; i < WIDTH; i++)
      fmask[i] = (s1.cfg.bit_idx == BW'(i));
  end

  assign f_en = (s1.cfg.mode != 2'b00) && s1.cfg.mask[s1.op];

  always_comb begin
    fres = gold[WIDTH-1:0];
    if (f_en) begin
      unique case (1'b1)
        (s1.cfg.mode == 2'b01): fres = gold[WIDTH-1:0] ^ fmask;
        (s1.cfg.mode == 2'b10): fres = gold[WIDTH-1:0] & ~fmask;
        default:                fres = gold[WIDTH-1:0] | fmask;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg      <= '0;
      s1       <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_zero  <= 1'b0;
      s2_carry <= 1'b0;
      s2_hit   <= 1'b0;
    end else begin
      if (bus.cfg_we)
        cfg <= '{mode:    bus.cfg_mode,
                 bit_idx: bus.cfg_bit,
                 mask:    bus.cfg_opmask};
      if (s1_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid)
          s1 <= '{a: bus.A, b: bus.B,
                  op: bus.opcode, cfg: cfg};
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_res   <= fres;
          s2_zero  <= (fres == '0);
          s2_carry <= gold[WIDTH];
          s2_hit   <= (fres != gold[WIDTH-1:0]);
        end
      end
    end
  end

  assign bus.in_ready   = s1_ready;
  assign bus.out_valid  = s2_valid;
  assign bus.result     = s2_res;
  assign bus.zero_flag  = s2_zero;
  assign bus.carry_flag = s2_carry;
  assign bus.fault_hit  = s2_hit;

`ifdef ALU_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (s2_valid && bus.out_ready && s2_hit && !(&cnt))
      cnt <= cnt + 1'b1;
  end

  assign bus.fault_count = cnt;
`else
  assign bus.fault_count = {CNT_W{1'b0}};
`endif

endmodule
